hazard_ctrl: RTL and testbench

//  Pipeline hazard and halt controller for the 5-stage RV32I core. Generates the flush/eflush

---
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | hazard_ctrl_if                                                             |
// | ID/EX/M/W hazard inputs and stall/flush/forward outputs of hazard_ctrl.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic              use_rs1_d;
  logic              use_rs2_d;
  logic              memread_e;
  logic              regwrite_m;
  logic              regwrite_w;
  logic              br_taken_e;
  logic              stop_e;
  logic              resume;
  logic              stall_pc;
  logic              stall_fd;
  logic              eflush;
  logic              flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d, memread_e,
           regwrite_m, regwrite_w, br_taken_e, stop_e, resume,
    input  stall_pc, stall_fd, eflush, flush, fwd_a, fwd_b, halted,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d, memread_e,
           regwrite_m, regwrite_w, br_taken_e, stop_e, resume,
    output stall_pc, stall_fd, eflush, flush, fwd_a, fwd_b, halted,
           stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | hazard_ctrl                                                                |
// | RV32I 5-stage hazard/halt controller: load-use stall, branch flush,        |
// | EX forwarding selects and ECALL drain/halt sequencing.                     |
// | Optional perf counters: define HAZARD_PERF_EN.                             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  wire logic    clk,
  input  wire logic    rstn,
  hazard_ctrl_if.slave hz
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_halt  = 2'd2;
  localparam logic [3:0] c_drain_init = 4'(DRAIN_CYCLES - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [3:0]        r_drain_cnt, w_drain_cnt_nxt;
  logic [REG_AW-1:0] r_rs1_e, r_rs2_e, r_rd_e, r_rd_m, r_rd_w;
  logic              w_lu, w_stop_req, w_hold, w_flush, w_eflush;

  assign w_stop_req = (r_state == c_st_run) && hz.stop_e && !hz.br_taken_e;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_m,
                                         input logic              we_w);
    if (we_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= c_st_run;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      c_st_run: begin
        if (w_stop_req) begin
          w_state_nxt     = c_st_drain;
          w_drain_cnt_nxt = c_drain_init;
        end
      end
      c_st_drain: begin
        if (r_drain_cnt == 4'd0) w_state_nxt = c_st_halt;
        else                     w_drain_cnt_nxt = r_drain_cnt - 4'd1;
      end
      c_st_halt: begin
        if (hz.resume) w_state_nxt = c_st_run;
      end
      default: w_state_nxt = c_st_run;
    endcase
  end

  // FSM / hazard outputs; a taken branch overrides every stall
  always_comb begin
    w_lu = hz.memread_e && (r_rd_e != '0) &&
           ((hz.use_rs1_d && (r_rd_e == hz.rs1_d)) ||
            (hz.use_rs2_d && (r_rd_e == hz.rs2_d)));
    w_flush  = hz.br_taken_e;
    w_hold   = (r_state != c_st_run) || w_stop_req || w_lu;
    w_eflush = !w_flush && w_hold;
    hz.flush    = w_flush;
    hz.stall_pc = w_eflush;
    hz.stall_fd = w_eflush;
    hz.eflush   = w_eflush;
    hz.halted   = (r_state == c_st_halt);
    hz.fwd_a    = fwd_sel(r_rs1_e, r_rd_m, r_rd_w, hz.regwrite_m, hz.regwrite_w);
    hz.fwd_b    = fwd_sel(r_rs2_e, r_rd_m, r_rd_w, hz.regwrite_m, hz.regwrite_w);
  end

  // Register-address shadow of the E/M/W control pipeline
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rs1_e <= '0;
      r_rs2_e <= '0;
      r_rd_e  <= '0;
      r_rd_m  <= '0;
      r_rd_w  <= '0;
    end else if (w_flush) begin
      r_rs1_e <= '0;
      r_rs2_e <= '0;
      r_rd_e  <= '0;
      r_rd_m  <= '0;
      r_rd_w  <= r_rd_m;
    end else if (w_eflush) begin
      r_rs1_e <= '0;
      r_rs2_e <= '0;
      r_rd_e  <= '0;
      r_rd_m  <= r_rd_e;
      r_rd_w  <= r_rd_m;
    end else begin
      r_rs1_e <= hz.rs1_d;
      r_rs2_e <= hz.rs2_d;
      r_rd_e  <= hz.rd_d;
      r_rd_m  <= r_rd_e;
      r_rd_w  <= r_rd_m;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_eflush && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl                                                             |
// | Directed self-checking bench for hazard_ctrl (DRAIN_CYCLES=2, CNT_W=2).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(2)) hz ();

  hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(2), .CNT_W(2)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rd_d = '0;
    hz.use_rs1_d = 1'b0; hz.use_rs2_d = 1'b0; hz.memread_e = 1'b0;
    hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0; hz.br_taken_e = 1'b0;
    hz.stop_e = 1'b0; hz.resume = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_stall_pc"}, 32'(hz.stall_pc), 32'(exp));
    check({tag, "_stall_fd"}, 32'(hz.stall_fd), 32'(exp));
    check({tag, "_eflush"},   32'(hz.eflush),   32'(exp));
  endtask

  // One load-use stall: load with rd=5 in EX, dependent add in ID
  task automatic do_lu();
    idle(); hz.rd_d = 5'd5; cyc();
    idle(); hz.memread_e = 1'b1; hz.rs1_d = 5'd5; hz.use_rs1_d = 1'b1; cyc();
    idle();
  endtask

  task automatic do_flush();
    idle(); hz.br_taken_e = 1'b1; cyc();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rstn = 1'b0;
    cyc(); cyc();

    // Reset state
    check_stall("rst", 1'b0);
    check("rst_flush",  32'(hz.flush),  32'h0);
    check("rst_fwd_a",  32'(hz.fwd_a),  32'h0);
    check("rst_fwd_b",  32'(hz.fwd_b),  32'h0);
    check("rst_halted", 32'(hz.halted), 32'h0);
    check("rst_scnt",   32'(hz.stall_cnt), 32'h0);
    check("rst_fcnt",   32'(hz.flush_cnt), 32'h0);
    rstn = 1'b1;

    // Load-use: lw x5 then add rs1=x5
    idle(); hz.rd_d = 5'd5; cyc();
    idle(); hz.memread_e = 1'b1; hz.rs1_d = 5'd5; hz.use_rs1_d = 1'b1; hz.rd_d = 5'd6; #1;
    check_stall("lu", 1'b1);
    check("lu_flush", 32'(hz.flush), 32'h0);
    cyc();
    hz.memread_e = 1'b0; #1;
    check_stall("lu_bubble", 1'b0);
    check("lu_bubble_fwd_a", 32'(hz.fwd_a), 32'h0);
    cyc();
    idle(); hz.regwrite_w = 1'b1; hz.regwrite_m = 1'b1; #1;
    check("lu_fwd_a_w", 32'(hz.fwd_a), 32'h1);
    check("lu_fwd_b", 32'(hz.fwd_b), 32'h0);

    // Load-use gating: rs2 path, use flag off, x0
    idle(); cyc(); cyc(); cyc();
    hz.rd_d = 5'd8; cyc();
    idle(); hz.memread_e = 1'b1; hz.rs2_d = 5'd8; hz.use_rs2_d = 1'b1; #1;
    check("lu_rs2", 32'(hz.stall_pc), 32'h1);
    hz.use_rs2_d = 1'b0; hz.rs1_d = 5'd8; #1;
    check("lu_nouse", 32'(hz.stall_pc), 32'h0);
    idle(); cyc();
    hz.memread_e = 1'b1; hz.use_rs1_d = 1'b1; #1;
    check("lu_x0", 32'(hz.stall_pc), 32'h0);

    // Forwarding: M beats W on same rd
    idle(); cyc(); cyc(); cyc();
    hz.rd_d = 5'd3; cyc();
    hz.rd_d = 5'd3; cyc();
    hz.rd_d = 5'd0; hz.rs1_d = 5'd3; hz.rs2_d = 5'd5; cyc();
    idle(); hz.regwrite_m = 1'b1; hz.regwrite_w = 1'b1; #1;
    check("fwd_m_beats_w", 32'(hz.fwd_a), 32'h2);
    check("fwd_b_none",    32'(hz.fwd_b), 32'h0);
    hz.regwrite_m = 1'b0; #1;
    check("fwd_w_only", 32'(hz.fwd_a), 32'h1);
    hz.regwrite_w = 1'b0; #1;
    check("fwd_no_we", 32'(hz.fwd_a), 32'h0);

    // Forwarding: distinct rd in M and W per operand
    idle(); cyc(); cyc(); cyc();
    hz.rd_d = 5'd3; cyc();
    hz.rd_d = 5'd7; cyc();
    hz.rd_d = 5'd0; hz.rs1_d = 5'd3; hz.rs2_d = 5'd7; cyc();
    idle(); hz.regwrite_m = 1'b1; hz.regwrite_w = 1'b1; #1;
    check("fwd_a_w_split", 32'(hz.fwd_a), 32'h1);
    check("fwd_b_m_split", 32'(hz.fwd_b), 32'h2);
    cyc();
    // rs1_e=rs2_e=0, rd_m=0, rd_w=7: x0 never forwarded
    check("fwd_x0_a", 32'(hz.fwd_a), 32'h0);

    // Flush beats load-use
    idle(); cyc(); cyc(); cyc();
    hz.rd_d = 5'd9; cyc();
    idle(); hz.memread_e = 1'b1; hz.rs1_d = 5'd9; hz.use_rs1_d = 1'b1;
    hz.br_taken_e = 1'b1; hz.rd_d = 5'd4; #1;
    check("br_flush", 32'(hz.flush), 32'h1);
    check_stall("br", 1'b0);
    cyc();
    idle(); hz.memread_e = 1'b1; hz.rs2_d = 5'd4; hz.use_rs2_d = 1'b1; hz.rs1_d = 5'd9; #1;
    check("br_rd_e_clr", 32'(hz.stall_pc), 32'h0);
    check("br_flush_drop", 32'(hz.flush), 32'h0);
    hz.memread_e = 1'b0; cyc();
    idle(); hz.regwrite_m = 1'b1; hz.regwrite_w = 1'b1; #1;
    check("br_rd_m_clr", 32'(hz.fwd_a), 32'h0);

    // ECALL drain and halt
    idle(); cyc(); cyc(); cyc();
    hz.stop_e = 1'b1; #1;
    check_stall("stop", 1'b1);
    check("stop_halted", 32'(hz.halted), 32'h0);
    cyc();
    idle(); hz.resume = 1'b1; #1;
    check("drain1_stall", 32'(hz.stall_pc), 32'h1);
    check("drain1_halted", 32'(hz.halted), 32'h0);
    cyc();
    hz.resume = 1'b0; #1;
    check("drain2_stall", 32'(hz.stall_pc), 32'h1);
    check("drain2_halted", 32'(hz.halted), 32'h0);
    cyc();
    check("halt_halted", 32'(hz.halted), 32'h1);
    check_stall("halt", 1'b1);
    cyc();
    check("halt_hold", 32'(hz.halted), 32'h1);
    hz.resume = 1'b1; #1;
    check("resume_same", 32'(hz.stall_pc), 32'h1);
    cyc();
    hz.resume = 1'b0; #1;
    check("resume_halted", 32'(hz.halted), 32'h0);
    check_stall("resume", 1'b0);

    // Reset mid-drain
    hz.stop_e = 1'b1; cyc();
    idle(); #1;
    check("pre_rst_drain", 32'(hz.stall_pc), 32'h1);
    rstn = 1'b0; cyc();
    rstn = 1'b1; #1;
    check_stall("rst_drain", 1'b0);
    check("rst_drain_halted", 32'(hz.halted), 32'h0);
    cyc(); cyc();
    check("rst_drain_later", 32'(hz.stall_pc), 32'h0);

    // stop_e with taken branch: no halt
    hz.stop_e = 1'b1; hz.br_taken_e = 1'b1; #1;
    check("stopbr_flush", 32'(hz.flush), 32'h1);
    check("stopbr_stall", 32'(hz.stall_pc), 32'h0);
    cyc();
    idle(); #1;
    check("stopbr_next", 32'(hz.stall_pc), 32'h0);
    cyc(); cyc(); cyc();
    check("stopbr_halted", 32'(hz.halted), 32'h0);

`ifdef HAZARD_PERF_EN
    rstn = 1'b0; cyc();
    rstn = 1'b1;
    do_lu(); do_lu(); do_lu();
    do_flush(); do_flush();
    check("perf_stall_cnt", 32'(hz.stall_cnt), 32'h3);
    check("perf_flush_cnt", 32'(hz.flush_cnt), 32'h2);
    do_lu(); do_flush(); do_flush();
    check("perf_stall_sat", 32'(hz.stall_cnt), 32'h3);
    check("perf_flush_sat", 32'(hz.flush_cnt), 32'h3);
`else
    do_lu(); do_flush();
    check("noperf_stall_cnt", 32'(hz.stall_cnt), 32'h0);
    check("noperf_flush_cnt", 32'(hz.flush_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
